// File: rtl/adc_spi_responder.sv
// Serial ADC stand-in: answers a 16-clock SPI frame with {zeros, ch[n]}, MSB first.
// Latency: dout follows an sclk falling edge by SYNC_STAGES+1 clk; frame pulses SYNC_STAGES+1 clk after the causing edge.
// Backpressure: none; the reader owns the pace, clk must run at least 8x sclk.
module adc_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              din,
  input  logic [DATA_W-1:0] ch0,
  input  logic [DATA_W-1:0] ch1,
  input  logic [DATA_W-1:0] ch2,
  input  logic [DATA_W-1:0] ch3,
  output logic              dout,
  output logic              dout_en,
  output logic [1:0]        cur_ch,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
  logic                   cs_q, sclk_q;
  logic                   cs_s, sclk_s, din_s;
  logic                   cs_fall, cs_rise, sclk_fall, sclk_rise;

  logic [FRAME_BITS-1:0]  word;
  logic [4:0]             bit_cnt;
  logic [1:0]             addr_sr;
  logic [1:0]             next_ch;
  logic [DATA_W-1:0]      ch_sel;
  logic                   load, done_set, err_set;

  // Bring the reader's pins into the clk domain; idle values match an idle bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      din_sync  <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
    end else begin
      cs_sync[0]   <= cs;
      sclk_sync[0] <= sclk;
      din_sync[0]  <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync[i]   <= cs_sync[i-1];
        sclk_sync[i] <= sclk_sync[i-1];
        din_sync[i]  <= din_sync[i-1];
      end
      cs_q   <= cs_sync[SYNC_STAGES-1];
      sclk_q <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign sclk_fall = sclk_q & ~sclk_s;
  assign sclk_rise = ~sclk_q & sclk_s;

  // Pick the channel that the next frame will convert.
  always_comb begin
    ch_sel = ch0;
    case (next_ch)
      2'd0:    ch_sel = ch0;
      2'd1:    ch_sel = ch1;
      2'd2:    ch_sel = ch2;
      default: ch_sel = ch3;
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decode; in IDLE only cs is looked at, so a coincident sclk edge is dropped.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          next_state = ACTIVE;
          load       = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          next_state = IDLE;
          err_set    = 1'b1;
        end else if (sclk_rise && bit_cnt == 5'(FRAME_BITS - 1)) begin
          next_state = DONE;
          done_set   = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: result shifter, edge counter, address capture and status pulses.
  // Only ADD1/ADD0 matter, so a 2-bit shifter clocked on rising edges 1..5 keeps exactly edges 4 and 5.
  // word is zeroed whenever no result bit is due, which makes dout = word[15] read 0 outside a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word       <= '0;
      bit_cnt    <= '0;
      addr_sr    <= '0;
      next_ch    <= '0;
      cur_ch     <= '0;
      dout_en    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= done_set;
      frame_err  <= err_set;
      case (state)
        IDLE: begin
          if (load) begin
            word    <= FRAME_BITS'(ch_sel);
            cur_ch  <= next_ch;
            bit_cnt <= '0;
            addr_sr <= '0;
            dout_en <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            word    <= '0;
            bit_cnt <= '0;
            dout_en <= 1'b0;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt < 5'd5) addr_sr <= {addr_sr[0], din_s};
            if (done_set) begin
              next_ch <= addr_sr;
              word    <= '0;
            end
          end else if (sclk_fall && bit_cnt != 5'd0) begin
            word <= {word[FRAME_BITS-2:0], 1'b0};
          end
        end
        DONE: begin
          if (cs_rise) begin
            bit_cnt <= '0;
            dout_en <= 1'b0;
          end
        end
        default: begin
          word    <= '0;
          dout_en <= 1'b0;
        end
      endcase
    end
  end

  assign dout = word[FRAME_BITS-1];

endmodule
